// File: rtl/openhmc_counter_feeder_if.sv
// openhmc_counter_feeder_if: event/clear inputs and counter-drive outputs of the feeder; overflow exists only with OPENHMC_FEEDER_OVERFLOW_EN
interface openhmc_counter_feeder_if #(
  parameter int EVENT_WIDTH   = 3,
  parameter int BACKLOG_WIDTH = 8
);
  logic                     event_valid;
  logic [EVENT_WIDTH-1:0]   event_count;
  logic                     clear;
  logic                     increment;
  logic                     load_enable;
  logic [BACKLOG_WIDTH-1:0] backlog;
  logic                     busy;
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
  logic                     overflow;
  modport master (output event_valid, event_count, clear,
                  input  increment, load_enable, backlog, busy, overflow);
  modport slave  (input  event_valid, event_count, clear,
                  output increment, load_enable, backlog, busy, overflow);
`else
  modport master (output event_valid, event_count, clear,
                  input  increment, load_enable, backlog, busy);
  modport slave  (input  event_valid, event_count, clear,
                  output increment, load_enable, backlog, busy);
`endif
endinterface

// File: rtl/openhmc_counter_feeder.sv
// openhmc_counter_feeder: turns multi-event cycles into single-step increments via a saturating backlog; sticky overflow flag with OPENHMC_FEEDER_OVERFLOW_EN
module openhmc_counter_feeder #(
  parameter int EVENT_WIDTH   = 3,
  parameter int BACKLOG_WIDTH = 8
) (
  input logic                     clk,
  input logic                     res_n,
  openhmc_counter_feeder_if.slave bus
);
  logic [EVENT_WIDTH-1:0]   ev;
  logic [BACKLOG_WIDTH:0]   ev_ext;
  logic [BACKLOG_WIDTH:0]   sum;
  logic [BACKLOG_WIDTH-1:0] next_backlog;
  logic                     pending;
  // Accepted events and the one-bit-wider next backlog; clear restarts from this cycle's events only
  always_comb begin
    ev = bus.event_valid ? bus.event_count : '0;
    ev_ext = (BACKLOG_WIDTH+1)'(ev);
    pending = bus.backlog != '0;
    sum = bus.clear ? ev_ext : {1'b0, bus.backlog} - (BACKLOG_WIDTH+1)'(pending) + ev_ext;
    next_backlog = sum[BACKLOG_WIDTH] ? '1 : sum[BACKLOG_WIDTH-1:0];
  end
  assign bus.busy = pending;
  // Issue one increment per cycle while backlog is pending; clear suppresses it so the load cannot wipe it
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bus.increment   <= 1'b0;
      bus.load_enable <= 1'b0;
      bus.backlog     <= '0;
    end else begin
      bus.increment   <= !bus.clear && pending;
      bus.load_enable <= bus.clear;
      bus.backlog     <= next_backlog;
    end
  end
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
  // Sticky saturation flag; a clear edge restarts it from its own sum
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) bus.overflow <= 1'b0;
    else bus.overflow <= sum[BACKLOG_WIDTH] || (!bus.clear && bus.overflow);
  end
`endif
endmodule

// File: tb/tb_openhmc_counter_feeder.sv
// tb_openhmc_counter_feeder: directed vectors, saturation, clear, async reset and random conservation checks with a downstream counter
module tb_openhmc_counter_feeder;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int total = 0;
  int bad = 0;
  int ds_cnt;

  openhmc_counter_feeder_if #(.EVENT_WIDTH(3), .BACKLOG_WIDTH(8)) bus ();
  openhmc_counter_feeder #(.EVENT_WIDTH(3), .BACKLOG_WIDTH(8)) dut (.clk(clk), .res_n(res_n), .bus(bus));

  always #5 clk = ~clk;

  // Downstream counter: load to zero on load_enable, else step on increment
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) ds_cnt <= 0;
    else if (bus.load_enable) ds_cnt <= 0;
    else if (bus.increment) ds_cnt <= ds_cnt + 1;
  end

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       clr;
    logic       inc;
    logic       le;
    int         bl;
    int         cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic clr);
    bus.event_valid = v;
    bus.event_count = c;
    bus.clear = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    int n;
    int acc;
    logic [2:0] c;
    logic v, clr;
    vecs[0]  = '{1, 3, 0, 0, 0, 3, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 2, 0};
    vecs[2]  = '{1, 0, 0, 1, 0, 1, 1};
    vecs[3]  = '{0, 0, 0, 1, 0, 0, 2};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 3};
    vecs[5]  = '{0, 7, 0, 0, 0, 0, 3};
    vecs[6]  = '{1, 5, 0, 0, 0, 5, 3};
    vecs[7]  = '{1, 2, 1, 0, 1, 2, 3};
    vecs[8]  = '{0, 0, 0, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 2};
    vecs[11] = '{1, 4, 0, 0, 0, 4, 2};
    vecs[12] = '{1, 1, 0, 1, 0, 4, 2};
    vecs[13] = '{0, 0, 1, 0, 1, 0, 3};
    vecs[14] = '{0, 0, 1, 0, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0};

    drive(0, 0, 0);
    #2;
    chk("reset_inc", int'(bus.increment), 0);
    chk("reset_le", int'(bus.load_enable), 0);
    chk("reset_backlog", int'(bus.backlog), 0);
    chk("reset_busy", int'(bus.busy), 0);
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
    chk("reset_ovf", int'(bus.overflow), 0);
`endif
    @(negedge clk);
    res_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].clr);
      step();
      chk($sformatf("vec%0d_inc", i), int'(bus.increment), int'(vecs[i].inc));
      chk($sformatf("vec%0d_le", i), int'(bus.load_enable), int'(vecs[i].le));
      chk($sformatf("vec%0d_backlog", i), int'(bus.backlog), vecs[i].bl);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].bl != 0));
      chk($sformatf("vec%0d_dscnt", i), ds_cnt, vecs[i].cnt);
    end

    drive(1, 7, 0);
    repeat (50) step();
    chk("sat_backlog", int'(bus.backlog), 255);
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
    chk("sat_ovf", int'(bus.overflow), 1);
`endif
    drive(0, 0, 0);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (bus.increment) n++;
      if (!bus.increment && bus.backlog == 0) break;
    end
    chk("sat_drain_incs", n, 255);
    chk("sat_drain_backlog", int'(bus.backlog), 0);
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
    chk("ovf_sticky", int'(bus.overflow), 1);
`endif

    drive(0, 0, 1);
    step();
    chk("clr2a_le", int'(bus.load_enable), 1);
    step();
    chk("clr2b_le", int'(bus.load_enable), 1);
    chk("clr2_inc", int'(bus.increment), 0);
    chk("clr2_backlog", int'(bus.backlog), 0);
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
    chk("clr2_ovf", int'(bus.overflow), 0);
`endif
    drive(0, 0, 0);
    step();
    chk("clr2_le_drop", int'(bus.load_enable), 0);

    drive(1, 7, 0);
    step();
    drive(1, 4, 0);
    step();
    chk("pre_rst_backlog", int'(bus.backlog), 10);
    drive(0, 0, 0);
    #2;
    res_n = 1'b0;
    #1;
    chk("arst_inc", int'(bus.increment), 0);
    chk("arst_le", int'(bus.load_enable), 0);
    chk("arst_backlog", int'(bus.backlog), 0);
    chk("arst_busy", int'(bus.busy), 0);
    @(negedge clk);
    res_n = 1'b1;
    n = 0;
    repeat (12) begin
      step();
      if (bus.increment || bus.load_enable) n++;
    end
    chk("post_rst_quiet", n, 0);

    acc = 0;
    for (int k = 0; k < 10000; k++) begin
      v = ($urandom_range(3) == 0);
      c = 3'($urandom_range(3));
      clr = ($urandom_range(499) == 0);
      drive(v, c, clr);
      if (clr) acc = v ? int'(c) : 0;
      else acc += v ? int'(c) : 0;
      step();
    end
    drive(0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      step();
      if (!bus.increment && bus.backlog == 0) break;
    end
    step();
    chk("rand_drained", int'(bus.backlog), 0);
    chk("rand_dscnt", ds_cnt, acc);
`ifdef OPENHMC_FEEDER_OVERFLOW_EN
    chk("rand_no_ovf", int'(bus.overflow), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
